// File: rtl/data_source.sv
// AXI-Stream packet generator: emits a burst of fixed-length packets carrying an incrementing 32-bit sequence.
// Optional one-cycle inter-packet gap when DATA_SOURCE_INTER_PACKET_GAP_EN is defined.
module data_source #(
  parameter int unsigned STREAM_WIDTH     = 512,
  parameter int unsigned BEATS_PER_PACKET = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [31:0]             packet_count,
  output logic                    busy,
  output logic                    done,
  output logic [STREAM_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  input  logic                    AXIS_TX_TREADY
);

  localparam int unsigned LANES = STREAM_WIDTH / 32;
  localparam int unsigned BW    = (BEATS_PER_PACKET > 1) ? $clog2(BEATS_PER_PACKET) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_PACKET - 1);

`ifdef DATA_SOURCE_INTER_PACKET_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
`else
  typedef enum logic {IDLE, SEND} state_e;
`endif

  state_e        state_q, state_d;
  logic [31:0]   seq_q, seq_d;
  logic [31:0]   pkts_q, pkts_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    pkts_d  = pkts_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (packet_count != '0) begin
            pkts_d  = packet_count;
            seq_d   = '0;
            beat_d  = '0;
            state_d = SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (AXIS_TX_TREADY) begin
          seq_d = seq_q + 32'd1;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            pkts_d = pkts_q - 32'd1;
            if (pkts_q == 32'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
`ifdef DATA_SOURCE_INTER_PACKET_GAP_EN
              state_d = GAP;
`else
              state_d = SEND;
`endif
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
`ifdef DATA_SOURCE_INTER_PACKET_GAP_EN
      GAP: state_d = SEND;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops directly.
  always_comb begin
    valid_d = (state_d == SEND);
    last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      seq_q   <= '0;
      pkts_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      pkts_q  <= pkts_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    AXIS_TX_TDATA = '0;
    if (valid_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        AXIS_TX_TDATA[i*32 +: 32] = seq_q;
      end
    end
  end

  assign AXIS_TX_TVALID = valid_q;
  assign AXIS_TX_TLAST  = last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/data_source.md
# data_source

AXI-Stream packet generator that drives the transmit side of the same stream interface that `data_sink` receives. On a start pulse it emits a programmed number of fixed-length packets carrying a deterministic incrementing pattern, honouring TREADY backpressure. It is the stimulus end of the RDMA data path, used to exercise the link and the downstream sink at full line rate.

## Interface

Parameters:
- `STREAM_WIDTH`, 512: TDATA width in bits; must be a multiple of 32.
- `BEATS_PER_PACKET`, 16: beats per packet; must be ≥ 1.

Ports:
- `clk`  in  1  the single clock; everything is synchronous to its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- `packet_count`  in  32  number of packets in the burst; latched when `start` is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted until the final beat is accepted.
- `done`  out  1  one-cycle pulse when the burst completes.
- `AXIS_TX_TDATA`  out  STREAM_WIDTH  beat data.
- `AXIS_TX_TVALID`  out  1  beat valid.
- `AXIS_TX_TLAST`  out  1  last beat of the packet.
- `AXIS_TX_TREADY`  in  1  downstream ready.

## Operation

- States: IDLE, SEND, and GAP (GAP exists only when the macro is defined).
- **IDLE:**
  - `start`=1 with `packet_count`≠0: latch the count, clear the 32-bit sequence number `seq`, clear the beat counter, go to SEND.
  - `start`=1 with `packet_count`=0: stay in IDLE; pulse `done` on the next cycle.
- **SEND:**
  - TVALID=1.
  - TDATA = `seq` replicated across all STREAM_WIDTH/32 lanes.
  - TLAST=1 when beat counter = BEATS_PER_PACKET−1.
- **On each accepted beat** (TVALID & TREADY):
  - `seq` increments and wraps 0xFFFFFFFF → 0.
  - The beat counter increments; it wraps to 0 after a TLAST beat, and the packet counter decrements.
- **TLAST beat accepted:**
  - Packet counter reaches 0: go to IDLE, TVALID=0, `busy`=0, `done`=1 for one cycle.
  - Otherwise: continue in SEND, or go to GAP when the macro is defined.
- **Boundaries:**
  - `start` while busy is ignored.
  - `packet_count` changes after latching are ignored.
  - BEATS_PER_PACKET=1: every beat carries TLAST.
- **Reset** (any state, including mid-packet): next edge returns to IDLE with all outputs 0. No beat is completed. `seq` restarts at 0 on the next burst.

## Timing

- Reset values: TDATA=0, TVALID=0, TLAST=0, `busy`=0, `done`=0.
- Start latency: `start` high at edge N gives TVALID=1 and `busy`=1 after edge N+1.
- Outputs are registered; no combinational path from TREADY to any output.
- Backpressure: while TVALID=1 and TREADY=0, TDATA and TLAST hold stable. TVALID never deasserts mid-burst except in GAP.
- Throughput: one beat per cycle when TREADY=1. Packets run back-to-back with no idle cycle when the macro is undefined.
- Completion: with the final beat accepted at edge M, TVALID=0, `busy`=0 and `done`=1 after edge M; `done`=0 after edge M+1.
- `start` may be accepted in the cycle `done` is high; that cycle is already IDLE.

## Configuration

- Macro `DATA_SOURCE_INTER_PACKET_GAP_EN`.
- Defined: after each non-final TLAST beat is accepted, the FSM spends exactly one cycle in GAP with TVALID=0 and TLAST=0, then returns to SEND. `seq` continues and `busy` stays 1.
- Undefined: the GAP state is not built; packets are contiguous.

## Test plan

- **Contiguous burst:** BEATS_PER_PACKET=4, `packet_count`=2, TREADY held 1 → 8 beats on 8 consecutive cycles. Lanes carry 0…7; TLAST on values 3 and 7; `done` pulses the cycle after beat 7.
- **Backpressure:** TREADY pseudo-random at 50%, `packet_count`=3 → the sink sees values 0…11 in order with no drop or duplicate. TDATA/TLAST stable whenever TVALID=1 and TREADY=0.
- **Zero count:** `packet_count`=0 → TVALID never asserts; `busy` stays 0; `done`=1 exactly one cycle after `start`.
- **Start while busy:** re-pulse `start` with `packet_count`=5 mid-burst of 2 → only 2 packets sent, one `done` pulse.
- **Reset mid-packet:** `resetn` low during beat 2 → all outputs 0 the next cycle. A new `start` sends values from 0 again.
- **Macro defined:** `packet_count`=2, TREADY=1 → exactly one TVALID=0 cycle between value 3 and value 4; no gap after the final packet.
